// File: rtl/hazard_control_unit.sv
// Hazard/stall controller for the 5-stage RV32 core: load-use and ID-branch operand stalls, cache-miss freeze, taken-branch flush.
// Optional build macro HAZARD_PERF_CNT_EN adds stall/freeze/flush performance counters.
module hazard_control_unit #(
   parameter int MAX_STALL = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] IF_ID_rs1,
   input  logic [4:0] IF_ID_rs2,
   input  logic       IF_ID_use_rs1,
   input  logic       IF_ID_use_rs2,
   input  logic       IF_ID_branch,
   input  logic [4:0] ID_EX_rd,
   input  logic       ID_EX_regwrite,
   input  logic       ID_EX_memread,
   input  logic [4:0] EX_MEM_rd,
   input  logic       EX_MEM_memread,
   input  logic       branch_taken,
   input  logic       i_stall,
   input  logic       d_stall,
   output logic       pc_write,
   output logic       IF_ID_write,
   output logic       IF_ID_flush,
   output logic       ID_EX_flush,
   output logic       pipe_write,
   output logic [1:0] hazard_state
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_freeze_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   localparam int CW = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_HOLD   = 2'b01,
      ST_FREEZE = 2'b10
   } state_t;

   state_t        state_q, state_d, ret_q, ret_d, base_st, st_out;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] n_hz, n_ldu, n_alu, n_mem;
   logic          freeze, match_ex, match_mem;

   function automatic logic reg_match(input logic use_x, input logic [4:0] rs,
                                      input logic [4:0] rd);
      return use_x && (rd != 5'd0) && (rs == rd);
   endfunction

   assign freeze    = i_stall | d_stall;
   assign match_ex  = reg_match(IF_ID_use_rs1, IF_ID_rs1, ID_EX_rd) |
                      reg_match(IF_ID_use_rs2, IF_ID_rs2, ID_EX_rd);
   assign match_mem = reg_match(IF_ID_use_rs1, IF_ID_rs1, EX_MEM_rd) |
                      reg_match(IF_ID_use_rs2, IF_ID_rs2, EX_MEM_rd);

   // A load feeding the ID comparator needs two bubbles: one to reach MEM, one to reach WB/forward.
   always_comb begin
      n_ldu = '0;
      n_alu = '0;
      n_mem = '0;
      if (ID_EX_memread && match_ex)
         n_ldu = IF_ID_branch ? CW'(2) : CW'(1);
      if (IF_ID_branch && ID_EX_regwrite && !ID_EX_memread && match_ex)
         n_alu = CW'(1);
      if (IF_ID_branch && EX_MEM_memread && match_mem)
         n_mem = CW'(1);
      n_hz = n_ldu;
      if (n_alu > n_hz) n_hz = n_alu;
      if (n_mem > n_hz) n_hz = n_mem;
   end

   // The state the pipeline behaves as once any freeze has lifted.
   assign base_st = (state_q == ST_FREEZE) ? ret_q : state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         ret_q   <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      cnt_d   = cnt_q;
      if (freeze) begin
         state_d = ST_FREEZE;
         ret_d   = base_st;
      end else begin
         ret_d = ST_RUN;
         case (base_st)
            ST_HOLD: begin
               cnt_d   = cnt_q - CW'(1);
               state_d = (cnt_q <= CW'(1)) ? ST_RUN : ST_HOLD;
            end
            default: begin
               if (n_hz != '0) begin
                  cnt_d   = n_hz - CW'(1);
                  state_d = (n_hz > CW'(1)) ? ST_HOLD : ST_RUN;
               end else begin
                  state_d = ST_RUN;
               end
            end
         endcase
      end
   end

   // Priority: freeze, then stall (HOLD or fresh hazard), then taken-branch flush.
   always_comb begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      IF_ID_flush = 1'b0;
      ID_EX_flush = 1'b0;
      pipe_write  = 1'b0;
      st_out      = ST_RUN;
      if (!rst_n) begin
         st_out = ST_RUN;
      end else if (freeze) begin
         st_out = ST_FREEZE;
      end else if ((base_st == ST_HOLD) || (n_hz != '0)) begin
         ID_EX_flush = 1'b1;
         pipe_write  = 1'b1;
         st_out      = base_st;
      end else begin
         pc_write    = 1'b1;
         IF_ID_write = 1'b1;
         pipe_write  = 1'b1;
         IF_ID_flush = branch_taken;
         st_out      = ST_RUN;
      end
   end

   assign hazard_state = st_out;

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt  <= '0;
         perf_freeze_cnt <= '0;
         perf_flush_cnt  <= '0;
      end else begin
         perf_stall_cnt  <= perf_stall_cnt + 32'(ID_EX_flush);
         perf_freeze_cnt <= perf_freeze_cnt + 32'(freeze);
         perf_flush_cnt  <= perf_flush_cnt + 32'(IF_ID_flush);
      end
   end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: directed vectors push expected outputs, a negedge monitor pops and compares.
module tb_hazard_control_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd, EX_MEM_rd;
   logic       IF_ID_use_rs1, IF_ID_use_rs2, IF_ID_branch;
   logic       ID_EX_regwrite, ID_EX_memread, EX_MEM_memread;
   logic       branch_taken, i_stall, d_stall;
   logic       pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_write;
   logic [1:0] hazard_state;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_freeze_cnt, perf_flush_cnt;
`endif

   always #5 clk = ~clk;

   hazard_control_unit #(.MAX_STALL(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
      .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
      .IF_ID_branch(IF_ID_branch),
      .ID_EX_rd(ID_EX_rd), .ID_EX_regwrite(ID_EX_regwrite), .ID_EX_memread(ID_EX_memread),
      .EX_MEM_rd(EX_MEM_rd), .EX_MEM_memread(EX_MEM_memread),
      .branch_taken(branch_taken), .i_stall(i_stall), .d_stall(d_stall),
      .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
      .ID_EX_flush(ID_EX_flush), .pipe_write(pipe_write), .hazard_state(hazard_state)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_freeze_cnt(perf_freeze_cnt),
      .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_write, hazard_state}
   localparam logic [6:0] E_RST    = 7'b00000_00;
   localparam logic [6:0] E_NORM   = 7'b11001_00;
   localparam logic [6:0] E_FLUSH  = 7'b11101_00;
   localparam logic [6:0] E_STL_R  = 7'b00011_00;
   localparam logic [6:0] E_STL_H  = 7'b00011_01;
   localparam logic [6:0] E_FREEZE = 7'b00000_10;

   typedef struct {
      logic [6:0] v;
      int         id;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t       e;
         logic [6:0] got;
         e   = exp_q.pop_front();
         got = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_write, hazard_state};
         n_total++;
         if (got === e.v) n_pass++;
         else $display("FAIL vec%0d: got %b required %b", e.id, got, e.v);
      end
   end

   task automatic clear_in();
      IF_ID_rs1 = '0; IF_ID_rs2 = '0; IF_ID_use_rs1 = 0; IF_ID_use_rs2 = 0;
      IF_ID_branch = 0; ID_EX_rd = '0; ID_EX_regwrite = 0; ID_EX_memread = 0;
      EX_MEM_rd = '0; EX_MEM_memread = 0; branch_taken = 0; i_stall = 0; d_stall = 0;
   endtask

   // Inputs are already applied; queue the expectation and advance to one step past the next edge.
   task automatic expect_cycle(input logic [6:0] v, input int id);
      exp_t e;
      e.v = v;
      e.id = id;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_in();
      @(posedge clk);
      #1;
      expect_cycle(E_RST, 1);
      rst_n = 1'b1;
      expect_cycle(E_NORM, 2);

      // load-use on rs2: one bubble, no HOLD
      ID_EX_memread = 1; ID_EX_regwrite = 1; ID_EX_rd = 5'd5; IF_ID_rs2 = 5'd5; IF_ID_use_rs2 = 1;
      expect_cycle(E_STL_R, 3);
      ID_EX_memread = 0; ID_EX_regwrite = 0; ID_EX_rd = 0; EX_MEM_memread = 1; EX_MEM_rd = 5'd5;
      expect_cycle(E_NORM, 4);

      // rd=0 never matches
      clear_in();
      ID_EX_memread = 1; ID_EX_rd = 5'd0; IF_ID_rs1 = 5'd0; IF_ID_use_rs1 = 1;
      expect_cycle(E_NORM, 5);

      // branch after load: two bubbles, HOLD masks detection and ignores branch_taken
      clear_in();
      IF_ID_branch = 1; IF_ID_rs1 = 5'd7; IF_ID_use_rs1 = 1; ID_EX_memread = 1; ID_EX_regwrite = 1; ID_EX_rd = 5'd7;
      expect_cycle(E_STL_R, 6);
      ID_EX_memread = 0; ID_EX_regwrite = 0; ID_EX_rd = 0; EX_MEM_memread = 1; EX_MEM_rd = 5'd7; branch_taken = 1;
      expect_cycle(E_STL_H, 7);
      EX_MEM_memread = 0;
      expect_cycle(E_FLUSH, 8);

      // taken branch with an ALU dependency: stall beats flush, then flush
      clear_in();
      IF_ID_branch = 1; IF_ID_rs2 = 5'd3; IF_ID_use_rs2 = 1; ID_EX_regwrite = 1; ID_EX_rd = 5'd3; branch_taken = 1;
      expect_cycle(E_STL_R, 9);
      ID_EX_regwrite = 0; ID_EX_rd = 0;
      expect_cycle(E_FLUSH, 10);

      // freeze in HOLD with cnt=1, then one remaining stall cycle
      clear_in();
      IF_ID_branch = 1; IF_ID_rs1 = 5'd9; IF_ID_use_rs1 = 1; ID_EX_memread = 1; ID_EX_rd = 5'd9;
      expect_cycle(E_STL_R, 11);
      ID_EX_memread = 0; ID_EX_rd = 0; d_stall = 1;
      expect_cycle(E_FREEZE, 12);
      expect_cycle(E_FREEZE, 13);
      expect_cycle(E_FREEZE, 14);
      d_stall = 0;
      expect_cycle(E_STL_H, 15);
      clear_in();
      expect_cycle(E_NORM, 16);

      // d_stall and load-use together: freeze first, load-use re-detected on release
      ID_EX_memread = 1; ID_EX_rd = 5'd12; IF_ID_rs1 = 5'd12; IF_ID_use_rs1 = 1; d_stall = 1;
      expect_cycle(E_FREEZE, 17);
      d_stall = 0;
      expect_cycle(E_STL_R, 18);
      clear_in();
      expect_cycle(E_NORM, 19);

      // i_stall outranks a taken branch, then async reset while frozen
      branch_taken = 1; i_stall = 1;
      expect_cycle(E_FREEZE, 20);
      rst_n = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
      #1;
      n_total++;
      if ({perf_stall_cnt, perf_freeze_cnt, perf_flush_cnt} === 96'd0) n_pass++;
      else $display("FAIL perf_reset: got %0d %0d %0d required 0 0 0",
                    perf_stall_cnt, perf_freeze_cnt, perf_flush_cnt);
`endif
      expect_cycle(E_RST, 21);
      rst_n = 1'b1;
      clear_in();
      expect_cycle(E_NORM, 22);
      expect_cycle(E_NORM, 23);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_total += exp_q.size();
         $display("FAIL drain: got %0d unchecked vectors required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
